// File: rtl/spi_cmd_pkg.sv
// Purpose: shared command codes, FSM state type and frame-length helpers for the gimbal SPI command engine.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_cmd_pkg;

  // Host command codes
  localparam logic [7:0] CMD_RESET      = 8'hFF;
  localparam logic [7:0] CMD_SET_PITCH  = 8'h11;
  localparam logic [7:0] CMD_GET_PITCH  = 8'h12;
  localparam logic [7:0] CMD_SET_YAW    = 8'h21;
  localparam logic [7:0] CMD_GET_YAW    = 8'h22;
  localparam logic [7:0] CMD_TOGGLE_LED = 8'h31;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // Number of SPI bits clocked for a given command; unknown codes send only the id byte
  function automatic logic [5:0] frame_bits(input logic [7:0] id);
    case (id)
      CMD_SET_PITCH, CMD_SET_YAW: frame_bits = 6'd32;
      CMD_GET_PITCH, CMD_GET_YAW: frame_bits = 6'd24;
      default:                    frame_bits = 6'd8;
    endcase
  endfunction

  // GET commands are the only ones whose MISO data is reported back
  function automatic logic cmd_is_get(input logic [7:0] id);
    cmd_is_get = (id == CMD_GET_PITCH) || (id == CMD_GET_YAW);
  endfunction

  function automatic logic cmd_known(input logic [7:0] id);
    case (id)
      CMD_RESET, CMD_SET_PITCH, CMD_GET_PITCH,
      CMD_SET_YAW, CMD_GET_YAW, CMD_TOGGLE_LED: cmd_known = 1'b1;
      default:                                  cmd_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_cmd_master_clk_div.sv
// Purpose: SPI half-period tick generator; counts 0..CLK_DIV-1 and ticks on the last count.
// Latency: first tick CLK_DIV cycles after a clear (acts on the CLK_DIV-th edge).
// Backpressure: none; free-running apart from the synchronous clear.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  // Wrap-around divider, restarted so the first half-period after a clear is full length
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/spi_cmd_master.sv
// Purpose: turns single-cycle host commands into framed MSB-first SPI transactions and returns GET counts.
// Latency: rsp_valid CLK_DIV*(2*nbits+2+CS_GAP) cycles after acceptance (nbits = 8, 24 or 32).
// Backpressure: cmd_ready low from the cycle after acceptance until the rsp_valid cycle; cmd_valid ignored while busy.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int CS_GAP        = 2,
  parameter int MSG_WIDTH     = 8,
  parameter int QD_DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [MSG_WIDTH-1:0]     cmd_id,
  input  logic                     cmd_dir,
  input  logic [13:0]              cmd_pwm,
  output logic                     rsp_valid,
  output logic [QD_DATA_WIDTH-1:0] rsp_count,
  output logic                     rsp_err,
  output logic                     SPI_CLK,
  output logic                     SPI_CS,
  output logic                     SPI_MOSI,
  input  logic                     SPI_MISO
);

  // Longest frame is four words (SET: id, dir byte, pwm high, pwm low)
  localparam int FRAME_W = 4 * MSG_WIDTH;
  localparam int GW      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_t                     state;
  logic [FRAME_W-1:0]         frame_word;
  logic [FRAME_W-1:0]         tx_sh;
  logic [QD_DATA_WIDTH-1:0]   rx_sh;
  logic [5:0]                 bit_cnt;
  logic [GW-1:0]              gap_cnt;
  logic [MSG_WIDTH-1:0]       id_q;
  logic                       accept;
  logic                       tick;

  // cmd_ready is only high in IDLE, so this is the single acceptance strobe
  assign accept = cmd_valid && cmd_ready;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  // Left-align the outgoing frame so the MSB always sits at the top of the shifter
  always_comb begin
    frame_word = '0;
    case (frame_bits(cmd_id))
      6'd32:   frame_word = {cmd_id, 7'b0, cmd_dir, 2'b0, cmd_pwm};
      6'd24:   frame_word = {cmd_id, 16'h0000, 8'h00};
      default: frame_word = {cmd_id, 24'h000000};
    endcase
  end

  // Frame sequencer: IDLE -> SETUP -> SHIFT (rise/fall pairs) -> HOLD -> GAP -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      SPI_CS    <= 1'b1;
      SPI_CLK   <= 1'b0;
      SPI_MOSI  <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_count <= '0;
      rsp_err   <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      id_q      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            id_q      <= cmd_id;
            tx_sh     <= frame_word << 1;
            SPI_MOSI  <= frame_word[FRAME_W-1];
            SPI_CS    <= 1'b0;
            cmd_ready <= 1'b0;
            bit_cnt   <= frame_bits(cmd_id);
            rx_sh     <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // First MOSI bit settles for a full half-period before the first rising edge
          if (tick) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!SPI_CLK) begin
              // Rising edge: the slave samples MOSI and updates MISO
              SPI_CLK <= 1'b1;
            end else begin
              // Falling edge: capture MISO and advance to the next MOSI bit
              SPI_CLK <= 1'b0;
              rx_sh   <= {rx_sh[QD_DATA_WIDTH-2:0], SPI_MISO};
              bit_cnt <= bit_cnt - 1'b1;
              if (bit_cnt == 6'd1) begin
                SPI_MOSI <= 1'b0;
                state    <= HOLD;
              end else begin
                SPI_MOSI <= tx_sh[FRAME_W-1];
                tx_sh    <= tx_sh << 1;
              end
            end
          end
        end
        HOLD: begin
          // Keep CS low for one half-period after the last falling edge
          if (tick) begin
            SPI_CS  <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == GW'(CS_GAP - 1)) begin
              rsp_valid <= 1'b1;
              rsp_count <= cmd_is_get(id_q) ? rx_sh : '0;
              rsp_err   <= !cmd_known(id_q);
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- Command engine for the gimbal SPI link: converts single-cycle host requests (set/get pitch and yaw, toggle LED, reset) into framed, MSB-first SPI transactions toward the FPGA-side SPI slave.
- Runs entirely on the system clock and generates SPI_CLK by division.
- Returns the 16-bit quadrature count for GET commands.
- Sits between the host controller logic and the four SPI pins.

Parameters:
- CLK_DIV, 4: system clocks per SPI_CLK half-period (≥2).
- CS_GAP, 2: half-periods SPI_CS held high after a frame before the next may start (≥1).
- MSG_WIDTH, 8: bits per SPI word.
- QD_DATA_WIDTH, 16: width of the returned count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  request strobe.
- cmd_ready  out  1  engine idle; request accepted on cmd_valid && cmd_ready.
- cmd_id  in  8  command code.
- cmd_dir  in  1  direction bit for SET commands.
- cmd_pwm  in  14  duty value for SET commands.
- rsp_valid  out  1  one-cycle pulse at frame completion.
- rsp_count  out  QD_DATA_WIDTH  count read by GET; zero otherwise.
- rsp_err  out  1  valid with rsp_valid; 1 for an unknown cmd_id.
- SPI_CLK  out  1  SPI clock, idle low.
- SPI_CS  out  1  chip select, active low.
- SPI_MOSI  out  1  master data out.
- SPI_MISO  in  1  slave data in.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, cmd_ready=1, rsp_valid=0, rsp_count=0, rsp_err=0, state IDLE.
- Reset mid-frame aborts immediately to these values. No rsp_valid is issued for the aborted frame.
- Input capture: cmd_id, cmd_dir and cmd_pwm are registered on acceptance. cmd_ready drops the cycle after acceptance and stays low until the rsp_valid cycle. cmd_valid while busy is ignored.
- Frames (MSB first, bytes in order):
  - 0xFF RESET and 0x31 TOGGLE_LED: 8 bits, {cmd_id}.
  - 0x11 SET_PITCH and 0x21 SET_YAW: 32 bits, {cmd_id, 7'b0 & cmd_dir, 2'b0 & cmd_pwm[13:8], cmd_pwm[7:0]}.
  - 0x12 GET_PITCH and 0x22 GET_YAW: 24 bits, {cmd_id, 16'h0000}. The MISO bits sampled during the last 16 bits form rsp_count, MSB first.
  - Any other code: 8-bit frame {cmd_id}; rsp_err=1 on completion.
- Half-period tick: a divider counts 0..CLK_DIV-1 and ticks at CLK_DIV-1. The divider is cleared on acceptance.
- State machine:
  - IDLE: on acceptance, set SPI_CS=0 and drive SPI_MOSI = frame MSB, then go to SETUP.
  - SETUP: one half-period, SPI_CLK low, then go to SHIFT.
  - SHIFT: toggle SPI_CLK on each tick.
    - Rising edge: the slave samples; the master does nothing.
    - Falling edge: sample SPI_MISO into the rx shift register, decrement the 6-bit bit counter, and present the next MOSI bit.
    - After the falling edge of the last bit, go to HOLD with SPI_MOSI=0.
  - HOLD: one half-period, SPI_CLK low, SPI_CS still 0, then set SPI_CS=1 and go to GAP.
  - GAP: CS_GAP half-periods with SPI_CS=1. At the end, pulse rsp_valid, load rsp_count and rsp_err, set cmd_ready=1, and return to IDLE.
- Latency: rsp_valid asserts exactly CLK_DIV*(2*nbits + 2 + CS_GAP) cycles after the accepting edge, where nbits ∈ {8, 24, 32}.
- rsp_count and rsp_err hold their values until the next rsp_valid.
- SPI_CLK never glitches. Each high and low phase lasts exactly CLK_DIV cycles.
- SPI_CS never toggles mid-frame.

Decomposition:
- Package spi_cmd_pkg holds:
  - command code constants: RESET 0xFF, SET_PITCH 0x11, GET_PITCH 0x12, SET_YAW 0x21, GET_YAW 0x22, TOGGLE_LED 0x31;
  - the state enum {IDLE, SETUP, SHIFT, HOLD, GAP};
  - a function mapping cmd_id to frame length in bits.
- Sub-module spi_clk_div: half-period tick generator with a synchronous clear.
- Frame assembly, the tx/rx shift registers and the FSM stay in the top module.

Test Plan:
1. CLK_DIV=2, CS_GAP=2, cmd 0x31 → MOSI bits 0x31 captured on SPI_CLK rising edges; exactly 8 rising edges with SPI_CS low; rsp_valid at cycle 2*(16+2+2)=40; rsp_err=0; rsp_count=0.
2. SET_YAW with dir=1, pwm=14'h1ABC → captured bytes 0x21, 0x01, 0x1A, 0xBC; 32 clocks; rsp_valid at cycle 2*(64+4)=136.
3. GET_PITCH with the slave model driving 0xBEEF on its rising edges after the command byte → rsp_count=16'hBEEF, rsp_err=0, 24 clocks.
4. cmd_id 0x55 → 8-bit frame 0x55; rsp_err=1; rsp_count=0.
5. Back-to-back: cmd_valid held high with two GET_YAW requests → second acceptance on the rsp_valid cycle; SPI_CS high for ≥ CS_GAP*CLK_DIV cycles between frames; a third cmd_valid pulse while busy is ignored.
6. rst asserted at bit 12 of a SET_PITCH frame → next cycle SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, cmd_ready=1, no rsp_valid; a following RESET command completes normally.
